// File: rtl/register_scoreboard.sv
// register_scoreboard
//   Issue-side scoreboard for the Read stage. Holds one decoded instruction,
//   tracks outstanding writes per architectural register and only lets the
//   held instruction read the register file once its sources have no
//   pending writer.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   EMPTY | no instruction held; Decode may always hand one over
//   HELD  | one instruction held; waiting for hazards to clear and Read
//
//   Ports
//     clk, reset                 clock / async active-low reset
//     decValidIn, decReadyOut    Decode handshake
//     sourceReg{1,2}In/ValidIn   source fields of the offered instruction
//     destRegIn/ValidIn          primary destination
//     destRegisterSpecial*In     secondary destination (e.g. RDX for IMUL)
//     canReadOut, stallOut       drive Read canReadIn / stallIn
//     isReadSuccessfulIn         Read accepted the held instruction
//     wb*In                      two writeback release ports
//     flushIn                    pipeline flush
//     busyMaskOut                per-register "write pending" flags
//     stallCountOut              cycles spent with stallOut high (wraps)
//     underflowErrOut            sticky: writeback on an idle register
module register_scoreboard #(
   parameter int NUM_REGS = 16,
   parameter int CNT_W    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                decValidIn,
   output logic                decReadyOut,
   input  logic [3:0]          sourceReg1In,
   input  logic [3:0]          sourceReg2In,
   input  logic                sourceReg1ValidIn,
   input  logic                sourceReg2ValidIn,
   input  logic [3:0]          destRegIn,
   input  logic                destRegValidIn,
   input  logic [3:0]          destRegisterSpecialIn,
   input  logic                destRegisterSpecialValidIn,
   output logic                canReadOut,
   output logic                stallOut,
   input  logic                isReadSuccessfulIn,
   input  logic                wbValidIn,
   input  logic [3:0]          wbRegIn,
   input  logic                wbSpecialValidIn,
   input  logic [3:0]          wbSpecialRegIn,
   input  logic                flushIn,
   output logic [NUM_REGS-1:0] busyMaskOut,
   output logic [31:0]         stallCountOut,
   output logic                underflowErrOut
);

   typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

   typedef struct packed {
      logic [3:0] src1;
      logic       src1_v;
      logic [3:0] src2;
      logic       src2_v;
      logic [3:0] dst;
      logic       dst_v;
      logic [3:0] spc;
      logic       spc_v;
   } instr_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q;
   instr_t           held_q;
   instr_t           instr_in;
   logic [CNT_W-1:0] cnt_q [NUM_REGS];
   logic [CNT_W-1:0] cnt_d [NUM_REGS];
   logic [CNT_W:0]   sum_w [NUM_REGS];
   logic [CNT_W:0]   dec_w [NUM_REGS];
   logic [31:0]      stall_cnt_q;
   logic             err_q;
   logic             underflow;
   logic             hazard;
   logic             issue;
   logic             accept;

   assign instr_in = '{src1: sourceReg1In, src1_v: sourceReg1ValidIn,
                       src2: sourceReg2In, src2_v: sourceReg2ValidIn,
                       dst: destRegIn, dst_v: destRegValidIn,
                       spc: destRegisterSpecialIn, spc_v: destRegisterSpecialValidIn};

   // A full destination counter also stalls, so an issue can never overflow.
   always_comb begin
      hazard = 1'b0;
      if (state_q == HELD) begin
         hazard = (held_q.src1_v && (cnt_q[held_q.src1] != '0)) ||
                  (held_q.src2_v && (cnt_q[held_q.src2] != '0)) ||
                  (held_q.dst_v  && (cnt_q[held_q.dst]  == CNT_MAX)) ||
                  (held_q.spc_v  && (cnt_q[held_q.spc]  == CNT_MAX));
      end
   end

   assign canReadOut      = (state_q == HELD) && !hazard && !flushIn;
   assign stallOut        = (state_q == HELD) && hazard;
   assign issue           = canReadOut && isReadSuccessfulIn;
   assign decReadyOut     = !flushIn && ((state_q == EMPTY) || issue);
   assign accept          = decValidIn && decReadyOut;
   assign stallCountOut   = stall_cnt_q;
   assign underflowErrOut = err_q;

   // Net per-register change: at most +1 from issue (dest == special counts
   // once), up to -2 from the two writeback ports; result clamps at zero.
   always_comb begin
      underflow = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         sum_w[r] = {1'b0, cnt_q[r]} + (CNT_W+1)'(issue &&
                    ((held_q.dst_v && (held_q.dst == 4'(r))) ||
                     (held_q.spc_v && (held_q.spc == 4'(r)))));
         dec_w[r] = (CNT_W+1)'(wbValidIn && (wbRegIn == 4'(r))) +
                    (CNT_W+1)'(wbSpecialValidIn && (wbSpecialRegIn == 4'(r)));
         if (sum_w[r] < dec_w[r]) begin
            cnt_d[r]  = '0;
            underflow = 1'b1;
         end else begin
            cnt_d[r] = CNT_W'(sum_w[r] - dec_w[r]);
         end
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         busyMaskOut[r] = (cnt_q[r] != '0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= EMPTY;
         held_q      <= '0;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         stall_cnt_q <= stall_cnt_q + 32'(stallOut);
         if (flushIn) begin
            state_q <= EMPTY;
            for (int r = 0; r < NUM_REGS; r++) begin
               cnt_q[r] <= '0;
            end
         end else begin
            err_q <= err_q | underflow;
            if (accept) begin
               state_q <= HELD;
               held_q  <= instr_in;
            end else if (issue) begin
               state_q <= EMPTY;
            end
            for (int r = 0; r < NUM_REGS; r++) begin
               cnt_q[r] <= cnt_d[r];
            end
         end
      end
   end

endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard
//   Directed-vector bench for register_scoreboard. Inputs change on the
//   falling edge, outputs are sampled 1 ns later; each expected value is
//   worked out by hand from the scoreboard rules.
module tb_register_scoreboard;

   logic        clk;
   logic        reset;
   logic        dec_valid;
   logic        dec_ready;
   logic [3:0]  s1, s2, dst, spc;
   logic        s1v, s2v, dstv, spcv;
   logic        can_read, stall;
   logic        read_ok;
   logic        wbv, wbsv;
   logic [3:0]  wbr, wbsr;
   logic        flush;
   logic [15:0] busy;
   logic [31:0] stall_cnt;
   logic        uf_err;

   int checks   = 0;
   int failures = 0;

   register_scoreboard #(.NUM_REGS(16), .CNT_W(2)) dut (
      .clk                        (clk),
      .reset                      (reset),
      .decValidIn                 (dec_valid),
      .decReadyOut                (dec_ready),
      .sourceReg1In               (s1),
      .sourceReg2In               (s2),
      .sourceReg1ValidIn          (s1v),
      .sourceReg2ValidIn          (s2v),
      .destRegIn                  (dst),
      .destRegValidIn             (dstv),
      .destRegisterSpecialIn      (spc),
      .destRegisterSpecialValidIn (spcv),
      .canReadOut                 (can_read),
      .stallOut                   (stall),
      .isReadSuccessfulIn         (read_ok),
      .wbValidIn                  (wbv),
      .wbRegIn                    (wbr),
      .wbSpecialValidIn           (wbsv),
      .wbSpecialRegIn             (wbsr),
      .flushIn                    (flush),
      .busyMaskOut                (busy),
      .stallCountOut              (stall_cnt),
      .underflowErrOut            (uf_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [3:0] src1_r, input logic src1_ok,
                        input logic [3:0] dst_r, input logic dst_ok,
                        input logic [3:0] spc_r, input logic spc_ok);
      dec_valid = 1'b1;
      s1 = src1_r;  s1v = src1_ok;
      s2 = 4'd0;    s2v = 1'b0;
      dst = dst_r;  dstv = dst_ok;
      spc = spc_r;  spcv = spc_ok;
   endtask

   // Advance one clock and return all per-cycle strobes to idle.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      dec_valid = 1'b0;
      s1v = 1'b0; s2v = 1'b0; dstv = 1'b0; spcv = 1'b0;
      wbv = 1'b0; wbsv = 1'b0;
      flush = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_dec_ready"}, 32'(dec_ready), 32'd1);
      check({tag, "_can_read"},  32'(can_read),  32'd0);
      check({tag, "_stall"},     32'(stall),     32'd0);
      check({tag, "_busy"},      32'(busy),      32'd0);
      check({tag, "_stall_cnt"}, stall_cnt,      32'd0);
      check({tag, "_uf_err"},    32'(uf_err),    32'd0);
   endtask

   initial begin
      reset = 1'b0;
      dec_valid = 1'b0;
      s1 = '0; s2 = '0; dst = '0; spc = '0;
      s1v = 1'b0; s2v = 1'b0; dstv = 1'b0; spcv = 1'b0;
      read_ok = 1'b1;
      wbv = 1'b0; wbsv = 1'b0; wbr = '0; wbsr = '0;
      flush = 1'b0;
      #1;
      check_reset_values("rst");
      @(negedge clk);
      reset = 1'b1;

      // independent stream R1..R4, one issue per cycle
      for (int i = 1; i <= 4; i++) begin
         offer(4'd0, 1'b0, 4'(i), 1'b1, 4'd0, 1'b0);
         #1;
         if (i > 1) check("t1_can_read", 32'(can_read), 32'd1);
         check("t1_dec_ready", 32'(dec_ready), 32'd1);
         cyc();
      end
      #1;
      check("t1_last_can_read", 32'(can_read), 32'd1);
      cyc();
      #1;
      check("t1_busy", 32'(busy), 32'h001E);
      check("t1_empty", 32'(can_read), 32'd0);
      wbv = 1'b1; wbr = 4'd1; wbsv = 1'b1; wbsr = 4'd2;
      cyc();
      wbv = 1'b1; wbr = 4'd3; wbsv = 1'b1; wbsr = 4'd4;
      cyc();
      #1;
      check("t1_clr_busy", 32'(busy), 32'd0);
      check("t1_clr_err", 32'(uf_err), 32'd0);

      // RAW stall on R3, released by writeback in the third stalled cycle
      offer(4'd0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0);
      cyc();
      offer(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
      #1;
      check("t2_wr_can_read", 32'(can_read), 32'd1);
      cyc();
      for (int k = 0; k < 3; k++) begin
         if (k == 2) begin
            wbv = 1'b1; wbr = 4'd3;
         end
         #1;
         check("t2_stall", 32'(stall), 32'd1);
         check("t2_no_read", 32'(can_read), 32'd0);
         cyc();
      end
      #1;
      check("t2_unstall_read", 32'(can_read), 32'd1);
      check("t2_unstall_stall", 32'(stall), 32'd0);
      check("t2_stall_cnt", stall_cnt, 32'd3);
      cyc();
      #1;
      check("t2_empty", 32'(can_read), 32'd0);

      // saturation of R5 at 3 pending writes
      for (int i = 0; i < 4; i++) begin
         offer(4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0);
         #1;
         if (i == 3) check("t3_third_issue", 32'(can_read), 32'd1);
         cyc();
      end
      #1;
      check("t3_sat_stall", 32'(stall), 32'd1);
      check("t3_sat_no_read", 32'(can_read), 32'd0);
      check("t3_sat_dec_ready", 32'(dec_ready), 32'd0);
      cyc();
      wbv = 1'b1; wbr = 4'd5;
      #1;
      check("t3_wb_cycle_stall", 32'(stall), 32'd1);
      cyc();
      #1;
      check("t3_fourth_read", 32'(can_read), 32'd1);
      cyc();
      #1;
      check("t3_stall_cnt", stall_cnt, 32'd5);
      check("t3_busy", 32'(busy), 32'h0020);
      wbv = 1'b1; wbr = 4'd5; wbsv = 1'b1; wbsr = 4'd5;
      cyc();
      #1;
      check("t3_cnt_one_busy", 32'(busy), 32'h0020);
      check("t3_cnt_one_err", 32'(uf_err), 32'd0);
      wbv = 1'b1; wbr = 4'd5;
      cyc();
      #1;
      check("t3_cnt_zero_busy", 32'(busy), 32'd0);
      check("t3_cnt_zero_err", 32'(uf_err), 32'd0);

      // special destination
      offer(4'd0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b1);
      cyc();
      cyc();
      #1;
      check("t4_imul_busy", 32'(busy), 32'h0005);
      offer(4'd0, 1'b0, 4'd7, 1'b1, 4'd7, 1'b1);
      cyc();
      cyc();
      #1;
      check("t4_same_busy", 32'(busy), 32'h0085);
      wbv = 1'b1; wbr = 4'd7;
      cyc();
      #1;
      check("t4_r7_single", 32'(busy), 32'h0005);
      check("t4_r7_err", 32'(uf_err), 32'd0);
      wbv = 1'b1; wbr = 4'd0; wbsv = 1'b1; wbsr = 4'd2;
      cyc();
      #1;
      check("t4_clr_busy", 32'(busy), 32'd0);

      // simultaneous issue and writeback on R6, then double writeback underflow
      offer(4'd0, 1'b0, 4'd6, 1'b1, 4'd0, 1'b0);
      cyc();
      offer(4'd0, 1'b0, 4'd6, 1'b1, 4'd0, 1'b0);
      cyc();
      wbv = 1'b1; wbr = 4'd6;
      #1;
      check("t5_issue_read", 32'(can_read), 32'd1);
      cyc();
      #1;
      check("t5_net_busy", 32'(busy), 32'h0040);
      check("t5_net_err", 32'(uf_err), 32'd0);
      check("t5_empty", 32'(can_read), 32'd0);
      wbv = 1'b1; wbr = 4'd6; wbsv = 1'b1; wbsr = 4'd6;
      cyc();
      #1;
      check("t5_uf_busy", 32'(busy), 32'd0);
      check("t5_uf_err", 32'(uf_err), 32'd1);

      // flush while HELD and stalled
      offer(4'd0, 1'b0, 4'd8, 1'b1, 4'd0, 1'b0);
      cyc();
      offer(4'd8, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
      cyc();
      flush = 1'b1;
      #1;
      check("t6_pre_stall", 32'(stall), 32'd1);
      check("t6_pre_no_read", 32'(can_read), 32'd0);
      check("t6_pre_dec_ready", 32'(dec_ready), 32'd0);
      check("t6_pre_busy", 32'(busy), 32'h0100);
      cyc();
      #1;
      check("t6_post_can_read", 32'(can_read), 32'd0);
      check("t6_post_stall", 32'(stall), 32'd0);
      check("t6_post_busy", 32'(busy), 32'd0);
      check("t6_post_stall_cnt", stall_cnt, 32'd6);
      check("t6_post_err", 32'(uf_err), 32'd1);
      check("t6_post_dec_ready", 32'(dec_ready), 32'd1);

      // reset asserted mid-stall
      offer(4'd0, 1'b0, 4'd9, 1'b1, 4'd0, 1'b0);
      cyc();
      offer(4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
      cyc();
      #1;
      check("t7_stall", 32'(stall), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check_reset_values("t7_rst");
      #4;
      reset = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
